// File: rtl/qcore_reg_wr_arb.sv
// ---------------------------------------------------------------------------
// qcore_reg_wr_arb
//   Arbiter for the single write port (we/w_addr/w_dt) of the qcore register
//   bank. The core writeback path always wins when it writes. External
//   requesters (host, DMA, ext tProc) are served round-robin when the core
//   slot is idle. A starvation counter tracks how long the core has blocked a
//   pending external request. When the counter runs out, the core is stalled
//   for one cycle so an external requester can get through. Writes to
//   read-only or unmapped addresses are accepted and then dropped. They raise
//   a sticky error flag.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear, issued together with the bank clear
//   halt_i              core halt; freezes all arbitration state
//   core_we_i/addr/dt   core write request
//   core_stall_o        core must hold its request this cycle
//   ext_valid_i         one valid per external requester
//   ext_addr_i          7 bits per requester, requester i at [7i+6:7i]
//   ext_dt_i            32 bits per requester, requester i at [32i+31:32i]
//   ext_ready_o         combinational accept, one-hot or zero
//   we_o/w_addr_o/w_dt_o registered write to the bank, one cycle after accept
//   src_o               0 = core, 1+i = external i (0 while we_o is low)
//   err_o, err_src_o    sticky illegal-write flag and source of the first one
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module qcore_reg_wr_arb #(
  parameter int unsigned N_EXT      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  halt_i,
  input  logic                  core_we_i,
  input  logic [6:0]            core_addr_i,
  input  logic [31:0]           core_dt_i,
  output logic                  core_stall_o,
  input  logic [N_EXT-1:0]      ext_valid_i,
  input  logic [7*N_EXT-1:0]    ext_addr_i,
  input  logic [32*N_EXT-1:0]   ext_dt_i,
  output logic [N_EXT-1:0]      ext_ready_o,
  output logic                  we_o,
  output logic [6:0]            w_addr_o,
  output logic [31:0]           w_dt_o,
  output logic [2:0]            src_o,
  output logic                  err_o,
  output logic [2:0]            err_src_o
);

  typedef enum logic {ST_ARB, ST_FORCE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rrPtr_q, rrPtr_d;
  logic [7:0]  starveCnt_q, starveCnt_d;
  logic        we_q, we_d;
  logic [6:0]  wAddr_q, wAddr_d;
  logic [31:0] wDt_q, wDt_d;
  logic [2:0]  src_q, src_d;
  logic        err_q, err_d;
  logic [2:0]  errSrc_q, errSrc_d;

  logic [3:0]  extValidPad;
  logic        anyExtValid;
  logic        rrHit;
  logic [1:0]  rrIdx;
  logic [1:0]  rrNext;
  logic [2:0]  rrCand;
  logic [6:0]  extAddrSel;
  logic [31:0] extDtSel;
  logic        coreGnt;
  logic        extGnt;
  logic        wrValid;
  logic        wrLegal;
  logic [6:0]  wrAddr;
  logic [31:0] wrDt;
  logic [2:0]  wrSrc;

  // Writable map: all of dreg, wreg 0x20-0x25 only, and two sreg windows.
  // Everything else is read-only status or unmapped space.
  function automatic logic addrLegal(input logic [6:0] a);
    return (a <= 7'h25) ||
           ((a >= 7'h40) && (a <= 7'h42)) ||
           ((a >= 7'h4C) && (a <= 7'h4F));
  endfunction

  // Pad the valid vector to four bits so the rotating index is always in range.
  assign extValidPad = 4'(ext_valid_i);
  assign anyExtValid = |ext_valid_i;

  // Round-robin search: first valid requester at or after the pointer,
  // wrapping modulo N_EXT (which need not be a power of two).
  always_comb begin
    rrHit  = 1'b0;
    rrIdx  = 2'd0;
    rrCand = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(N_EXT)) begin
        rrCand = {1'b0, rrPtr_q} + 3'(k);
        if (rrCand >= 3'(N_EXT)) begin
          rrCand = rrCand - 3'(N_EXT);
        end
        if (!rrHit && extValidPad[rrCand[1:0]]) begin
          rrHit = 1'b1;
          rrIdx = rrCand[1:0];
        end
      end
    end
  end

  // The pointer moves to the requester after the winner, so the winner gets
  // lowest priority in the next round.
  assign rrNext = (({1'b0, rrIdx} + 3'd1) >= 3'(N_EXT)) ? 2'd0 : (rrIdx + 2'd1);

  // Pick out the round-robin winner's address and data from the flat buses.
  always_comb begin
    extAddrSel = 7'd0;
    extDtSel   = 32'd0;
    for (int i = 0; i < int'(N_EXT); i++) begin
      if (rrIdx == 2'(i)) begin
        extAddrSel = ext_addr_i[7*i +: 7];
        extDtSel   = ext_dt_i[32*i +: 32];
      end
    end
  end

  // Arbitration FSM. Clear wins over halt. Halt blocks all grants and keeps
  // every piece of state, so a pending forced slot survives the halt. In ARB
  // the core wins whenever it writes. FORCE lasts one cycle: if an external
  // request is still pending, the core is stalled and that request gets
  // through.
  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    starveCnt_d  = starveCnt_q;
    coreGnt      = 1'b0;
    extGnt       = 1'b0;
    core_stall_o = 1'b0;
    if (clear_i) begin
      state_d     = ST_ARB;
      rrPtr_d     = 2'd0;
      starveCnt_d = 8'd0;
    end else if (!halt_i) begin
      case (state_q)
        ST_ARB: begin
          if (core_we_i) begin
            coreGnt = 1'b1;
            if (anyExtValid) begin
              starveCnt_d = starveCnt_q + 8'd1;
              if (starveCnt_q == 8'(STARVE_MAX - 1)) begin
                state_d = ST_FORCE;
              end
            end
          end else begin
            starveCnt_d = 8'd0;
            if (rrHit) begin
              extGnt  = 1'b1;
              rrPtr_d = rrNext;
            end
          end
        end
        ST_FORCE: begin
          starveCnt_d = 8'd0;
          state_d     = ST_ARB;
          if (rrHit) begin
            extGnt       = 1'b1;
            core_stall_o = core_we_i;
            rrPtr_d      = rrNext;
          end else if (core_we_i) begin
            coreGnt = 1'b1;
          end
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end
  end

  // Accept exactly the requester the FSM granted.
  always_comb begin
    ext_ready_o = '0;
    for (int i = 0; i < int'(N_EXT); i++) begin
      ext_ready_o[i] = extGnt && (rrIdx == 2'(i));
    end
  end

  // Build the accepted write. The address check covers both sources. An
  // illegal write still uses up its slot but never reaches the bank. Idle
  // cycles drive zero on every write field.
  always_comb begin
    wrValid = coreGnt | extGnt;
    wrAddr  = coreGnt ? core_addr_i : extAddrSel;
    wrDt    = coreGnt ? core_dt_i : extDtSel;
    wrSrc   = coreGnt ? 3'd0 : ({1'b0, rrIdx} + 3'd1);
    wrLegal = addrLegal(wrAddr);
    we_d    = wrValid & wrLegal;
    wAddr_d = we_d ? wrAddr : 7'd0;
    wDt_d   = we_d ? wrDt : 32'd0;
    src_d   = we_d ? wrSrc : 3'd0;
  end

  // The error flag is sticky. err_src keeps the source of the first illegal
  // write until a clear or reset.
  always_comb begin
    err_d    = err_q;
    errSrc_d = errSrc_q;
    if (clear_i) begin
      err_d    = 1'b0;
      errSrc_d = 3'd0;
    end else if (wrValid && !wrLegal) begin
      err_d = 1'b1;
      if (!err_q) begin
        errSrc_d = wrSrc;
      end
    end
  end

  // State and output registers. Reset drops a pending write at once, so
  // requesters must present their request again after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARB;
      rrPtr_q     <= 2'd0;
      starveCnt_q <= 8'd0;
      we_q        <= 1'b0;
      wAddr_q     <= 7'd0;
      wDt_q       <= 32'd0;
      src_q       <= 3'd0;
      err_q       <= 1'b0;
      errSrc_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      starveCnt_q <= starveCnt_d;
      we_q        <= we_d;
      wAddr_q     <= wAddr_d;
      wDt_q       <= wDt_d;
      src_q       <= src_d;
      err_q       <= err_d;
      errSrc_q    <= errSrc_d;
    end
  end

  assign we_o      = we_q;
  assign w_addr_o  = wAddr_q;
  assign w_dt_o    = wDt_q;
  assign src_o     = src_q;
  assign err_o     = err_q;
  assign err_src_o = errSrc_q;

endmodule

// File: tb/tb_qcore_reg_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_qcore_reg_wr_arb
//   Self-checking bench for qcore_reg_wr_arb with N_EXT=2 and STARVE_MAX=8.
//   Each table row gives one cycle of inputs. It also gives the expected
//   combinational handshake for that cycle and the write the bank should see
//   one cycle later. Core data is derived from the core address. External
//   data is derived from the requester and its address. This lets the
//   expected write data be rebuilt from the row alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qcore_reg_wr_arb;

  localparam int N_EXT      = 2;
  localparam int STARVE_MAX = 8;

  logic          clk_i;
  logic          rst_ni;
  logic          clear_i;
  logic          halt_i;
  logic          core_we_i;
  logic [6:0]    core_addr_i;
  logic [31:0]   core_dt_i;
  logic          core_stall_o;
  logic [1:0]    ext_valid_i;
  logic [13:0]   ext_addr_i;
  logic [63:0]   ext_dt_i;
  logic [1:0]    ext_ready_o;
  logic          we_o;
  logic [6:0]    w_addr_o;
  logic [31:0]   w_dt_o;
  logic [2:0]    src_o;
  logic          err_o;
  logic [2:0]    err_src_o;

  typedef struct packed {
    logic        halt;
    logic        clear;
    logic        coreWe;
    logic [6:0]  coreAddr;
    logic [31:0] coreDt;
    logic [1:0]  extValid;
    logic [6:0]  extAddr0;
    logic [6:0]  extAddr1;
    logic        expStall;
    logic [1:0]  expReady;
    logic        expWe;
    logic [6:0]  expAddr;
    logic [2:0]  expSrc;
    logic        expErr;
    logic [2:0]  expErrSrc;
  } vec_t;

  typedef struct packed {
    logic [15:0] idx;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] dt;
    logic [2:0]  src;
    logic        err;
    logic [2:0]  errSrc;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  qcore_reg_wr_arb #(
    .N_EXT      (N_EXT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .halt_i       (halt_i),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_dt_i    (core_dt_i),
    .core_stall_o (core_stall_o),
    .ext_valid_i  (ext_valid_i),
    .ext_addr_i   (ext_addr_i),
    .ext_dt_i     (ext_dt_i),
    .ext_ready_o  (ext_ready_o),
    .we_o         (we_o),
    .w_addr_o     (w_addr_o),
    .w_dt_o       (w_dt_o),
    .src_o        (src_o),
    .err_o        (err_o),
    .err_src_o    (err_src_o)
  );

  // 100 MHz clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // A hung simulation still ends with a reported failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] coreData(input logic [6:0] a);
    return 32'hC0DE_0000 | {25'd0, a};
  endfunction

  function automatic logic [31:0] extData(input logic [2:0] i, input logic [6:0] a);
    return 32'hE000_0000 | ({29'd0, i} << 16) | {25'd0, a};
  endfunction

  function automatic vec_t mk(input logic h, input logic c, input logic we,
                              input logic [6:0] ca, input logic [1:0] ev,
                              input logic [6:0] a0, input logic [6:0] a1,
                              input logic stall, input logic [1:0] rdy,
                              input logic ew, input logic [6:0] ea,
                              input logic [2:0] es, input logic ee,
                              input logic [2:0] eer);
    vec_t v;
    v.halt      = h;
    v.clear     = c;
    v.coreWe    = we;
    v.coreAddr  = ca;
    v.coreDt    = coreData(ca);
    v.extValid  = ev;
    v.extAddr0  = a0;
    v.extAddr1  = a1;
    v.expStall  = stall;
    v.expReady  = rdy;
    v.expWe     = ew;
    v.expAddr   = ea;
    v.expSrc    = es;
    v.expErr    = ee;
    v.expErrSrc = eer;
    return v;
  endfunction

  function automatic logic [31:0] expData(input vec_t v);
    if (!v.expWe) return 32'd0;
    if (v.expSrc == 3'd0) return v.coreDt;
    return extData(v.expSrc - 3'd1, v.expAddr);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive a row at the falling edge and check the combinational handshake.
  // Then queue the write that must appear after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk_i);
    halt_i      = v.halt;
    clear_i     = v.clear;
    core_we_i   = v.coreWe;
    core_addr_i = v.coreAddr;
    core_dt_i   = v.coreDt;
    ext_valid_i = v.extValid;
    ext_addr_i  = {v.extAddr1, v.extAddr0};
    ext_dt_i    = {extData(3'd1, v.extAddr1), extData(3'd0, v.extAddr0)};
    #1;
    cmp("stall", idx, {63'd0, core_stall_o}, {63'd0, v.expStall});
    cmp("ready", idx, {62'd0, ext_ready_o}, {62'd0, v.expReady});
    e.idx    = 16'(idx);
    e.we     = v.expWe;
    e.addr   = v.expAddr;
    e.dt     = expData(v);
    e.src    = v.expSrc;
    e.err    = v.expErr;
    e.errSrc = v.expErrSrc;
    sbq.push_back(e);
  endtask

  // After the rising edge, take the oldest expectation and compare it with
  // the registered bank-side outputs.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending write");
    end else begin
      e = sbq.pop_front();
      cmp("write", int'(e.idx), {21'd0, we_o, w_addr_o, w_dt_o, src_o},
          {21'd0, e.we, e.addr, e.dt, e.src});
      cmp("error", int'(e.idx), {60'd0, err_o, err_src_o}, {60'd0, e.err, e.errSrc});
    end
  endtask

  // Build the vector table, run it, then run the reset-mid-transfer sequence.
  initial begin
    vec_t       t;
    logic [6:0] bAddr [12];
    logic       bLeg  [12];

    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    halt_i      = 1'b0;
    core_we_i   = 1'b0;
    core_addr_i = 7'd0;
    core_dt_i   = 32'd0;
    ext_valid_i = 2'b00;
    ext_addr_i  = 14'd0;
    ext_dt_i    = 64'd0;

    #12;
    cmp("reset", 0, {15'd0, we_o, w_addr_o, w_dt_o, src_o, err_o, err_src_o, core_stall_o, ext_ready_o},
        64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single core write with a distinctive data word.
    t = mk(1'b0,1'b0,1'b1,7'h05,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b1,7'h05,3'd0, 1'b0,3'd0);
    t.coreDt = 32'hDEAD_BEEF;
    tbl.push_back(t);
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b0,3'd0));

    // Core idle, both requesters valid: grants alternate.
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b11,7'h10,7'h21, 1'b0,2'b01, 1'b1,7'h10,3'd1, 1'b0,3'd0));
      tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b11,7'h10,7'h21, 1'b0,2'b10, 1'b1,7'h21,3'd2, 1'b0,3'd0));
    end
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b10,7'h10,7'h21, 1'b0,2'b10, 1'b1,7'h21,3'd2, 1'b0,3'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b01,7'h10,7'h21, 1'b0,2'b01, 1'b1,7'h10,3'd1, 1'b0,3'd0));

    // Starvation: eight core writes, then one forced ext0 slot with the core stalled.
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,7'(8+k),2'b01,7'h41,7'h00, 1'b0,2'b00, 1'b1,7'(8+k),3'd0, 1'b0,3'd0));
    end
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h10,2'b01,7'h41,7'h00, 1'b1,2'b01, 1'b1,7'h41,3'd1, 1'b0,3'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h10,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b1,7'h10,3'd0, 1'b0,3'd0));

    // Illegal ext1 write, then an illegal core write that must not overwrite err_src.
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b10,7'h00,7'h45, 1'b0,2'b10, 1'b0,7'h00,3'd0, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h7F,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h4C,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b1,7'h4C,3'd0, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h26,2'b01,7'h02,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b01,7'h02,7'h00, 1'b0,2'b01, 1'b1,7'h02,3'd1, 1'b1,3'd2));

    // Address map edges, written by the core.
    bAddr = '{7'h1F,7'h20,7'h25,7'h26,7'h3F,7'h40,7'h42,7'h43,7'h4B,7'h4C,7'h4F,7'h50};
    bLeg  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 12; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,bAddr[k],2'b00,7'h00,7'h00, 1'b0,2'b00,
                       bLeg[k], bLeg[k] ? bAddr[k] : 7'h00, 3'd0, 1'b1,3'd2));
    end

    // Halt for five cycles with the counter at 3; it must resume from 3.
    for (int k = 1; k <= 3; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,7'(k),2'b01,7'h11,7'h00, 1'b0,2'b00, 1'b1,7'(k),3'd0, 1'b1,3'd2));
    end
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b1,1'b0,1'b1,7'h04,2'b01,7'h11,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b1,3'd2));
    end
    for (int k = 4; k <= 8; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,7'(k),2'b01,7'h11,7'h00, 1'b0,2'b00, 1'b1,7'(k),3'd0, 1'b1,3'd2));
    end
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h09,2'b01,7'h11,7'h00, 1'b1,2'b01, 1'b1,7'h11,3'd1, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h09,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b1,7'h09,3'd0, 1'b1,3'd2));

    // A forced slot reached just before a halt is taken after the halt.
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,7'h0A,2'b01,7'h12,7'h00, 1'b0,2'b00, 1'b1,7'h0A,3'd0, 1'b1,3'd2));
    end
    tbl.push_back(mk(1'b1,1'b0,1'b1,7'h0B,2'b01,7'h12,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h0B,2'b01,7'h12,7'h00, 1'b1,2'b01, 1'b1,7'h12,3'd1, 1'b1,3'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,7'h0B,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b1,7'h0B,3'd0, 1'b1,3'd2));

    // Clear, asserted together with halt, with err set, counter at 5 and pointer at ext1.
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b0,1'b0,1'b1,7'h0C,2'b01,7'h13,7'h00, 1'b0,2'b00, 1'b1,7'h0C,3'd0, 1'b1,3'd2));
    end
    tbl.push_back(mk(1'b1,1'b1,1'b1,7'h0D,2'b11,7'h13,7'h22, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b0,3'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b11,7'h13,7'h22, 1'b0,2'b01, 1'b1,7'h13,3'd1, 1'b0,3'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b10,7'h00,7'h22, 1'b0,2'b10, 1'b1,7'h22,3'd2, 1'b0,3'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b01,7'h50,7'h00, 1'b0,2'b01, 1'b0,7'h00,3'd0, 1'b1,3'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b10,7'h00,7'h43, 1'b0,2'b10, 1'b0,7'h00,3'd0, 1'b1,3'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,7'h00,2'b00,7'h00,7'h00, 1'b0,2'b00, 1'b0,7'h00,3'd0, 1'b1,3'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], i);
      checkOutput();
    end

    // Reset asserted while a write is visible: we_o and err_o drop immediately.
    @(negedge clk_i);
    core_we_i   = 1'b1;
    core_addr_i = 7'h07;
    core_dt_i   = coreData(7'h07);
    @(posedge clk_i);
    #1;
    cmp("pre-reset write", 0, {56'd0, we_o, w_addr_o}, {56'd0, 1'b1, 7'h07});
    #2;
    rst_ni = 1'b0;
    #1;
    cmp("async reset", 0, {53'd0, we_o, w_addr_o, err_o, src_o}, 64'd0);
    @(negedge clk_i);
    core_we_i = 1'b0;
    rst_ni    = 1'b1;
    @(posedge clk_i);
    #1;
    cmp("post-reset idle", 0, {63'd0, we_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
